// File: rtl/mod_reducer.sv
// Limb-serial modular correction stage: repeatedly adds or subtracts M until X lies in [0, M).
// Optional macro REDUCE_FULL_EN enables multi-pass reduction (bounded by MAX_ITER).
module mod_reducer #(
  parameter int unsigned LIMB_W   = 64,
  parameter int unsigned N_LIMBS  = 9,
  parameter int unsigned MAX_ITER = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [513:0] in_x,
  input  logic [511:0] in_m,
  output logic [511:0] result,
  output logic         busy,
  output logic         done,
  output logic         range_err
);

  localparam int unsigned W     = LIMB_W * N_LIMBS;
  localparam int unsigned IDX_W = $clog2(N_LIMBS);
  localparam int unsigned CNT_W = $clog2(MAX_ITER + 1);

`ifdef REDUCE_FULL_EN
  localparam bit FULL_EN = 1'b1;
`else
  localparam bit FULL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CHECK, PASS, FINISH} state_t;

  state_t             state, state_nx;
  logic [W-1:0]       x_q, m_q, t_q, t_nx;
  logic               carry_q, op_sub_q, lim_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LIMB_W-1:0]  x_limb, m_limb;
  logic [LIMB_W:0]    sum;
  logic               last_limb, accept, at_limit, go_again, take;

  assign take = (state == IDLE) && start && !done;
  assign busy = (state != IDLE);

  always_comb begin
    x_limb    = x_q[idx_q*LIMB_W +: LIMB_W];
    m_limb    = op_sub_q ? ~m_q[idx_q*LIMB_W +: LIMB_W] : m_q[idx_q*LIMB_W +: LIMB_W];
    sum       = {1'b0, x_limb} + {1'b0, m_limb} + {{LIMB_W{1'b0}}, carry_q};
    t_nx      = t_q;
    t_nx[idx_q*LIMB_W +: LIMB_W] = sum[LIMB_W-1:0];
    last_limb = (idx_q == IDX_W'(N_LIMBS - 1));
    // A SUB is only kept when the final carry shows X - M did not borrow.
    accept    = !op_sub_q || sum[LIMB_W];
    at_limit  = (cnt_q == CNT_W'(MAX_ITER - 1));
    go_again  = FULL_EN && accept && !at_limit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = CHECK;
      CHECK:   state_nx = PASS;
      PASS:    if (last_limb) state_nx = go_again ? CHECK : FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      m_q       <= '0;
      t_q       <= '0;
      carry_q   <= 1'b0;
      op_sub_q  <= 1'b0;
      lim_q     <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      result    <= '0;
      range_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (take) begin
            x_q   <= {{(W-514){in_x[513]}}, in_x};
            m_q   <= {{(W-512){1'b0}}, in_m};
            cnt_q <= '0;
            lim_q <= 1'b0;
          end
        end
        CHECK: begin
          op_sub_q <= !x_q[W-1];
          carry_q  <= !x_q[W-1];
          idx_q    <= '0;
        end
        PASS: begin
          t_q     <= t_nx;
          carry_q <= sum[LIMB_W];
          idx_q   <= idx_q + 1'b1;
          if (last_limb) begin
            if (accept) x_q <= t_nx;
            cnt_q <= cnt_q + 1'b1;
            lim_q <= FULL_EN && accept && at_limit;
          end
        end
        FINISH: begin
          result    <= x_q[511:0];
          range_err <= x_q[W-1] | lim_q;
        end
        default: ;
      endcase
    end
  end

endmodule
